// File: rtl/uart_tx_if.sv
// uart_tx_if -- byte-in / serial-out signal bundle for uart_tx.
//   d_i     : byte to transmit, sampled only when a frame is accepted
//   start_i : level request to send d_i
//   tx_o    : serial line, idles high
//   busy_o  : high while a frame is in progress
//   done_o  : one-cycle pulse in the final cycle of the stop bit
// Modports: master (byte source / line observer), slave (the transmitter).
interface uart_tx_if;
    logic [7:0] d_i;
    logic       start_i;
    logic       tx_o;
    logic       busy_o;
    logic       done_o;

    modport master (output d_i, output start_i, input tx_o, input busy_o, input done_o);
    modport slave  (input d_i, input start_i, output tx_o, output busy_o, output done_o);
endinterface

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN defined).
// Parameters:
//   CLKS_PER_BIT : clk cycles per serial bit (>= 2)
// Ports:
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : uart_tx_if.slave (d_i, start_i in; tx_o, busy_o, done_o out)
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after
// the data bits.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 20
) (
    input  logic      clk,
    input  logic      resetn,
    uart_tx_if.slave  bus
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] TLOAD = TW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    idx, idx_next;
    logic [7:0]    shreg, shreg_next;
    logic          tx_q, tx_next;
    logic          busy, done;

    // State register; tx is registered from the next-state view so the line
    // changes on the same edge the state does.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            timer <= TLOAD;
            idx   <= '0;
            shreg <= '0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_next;
            timer <= timer_next;
            idx   <= idx_next;
            shreg <= shreg_next;
            tx_q  <= tx_next;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_next = state;
        timer_next = timer;
        idx_next   = idx;
        shreg_next = shreg;
        case (state)
            IDLE: begin
                timer_next = TLOAD;
                if (bus.start_i) begin
                    state_next = START;
                    shreg_next = bus.d_i;
                end
            end
            START: begin
                if (timer == '0) begin
                    state_next = DATA;
                    timer_next = TLOAD;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            DATA: begin
                if (timer == '0) begin
                    timer_next = TLOAD;
                    idx_next   = idx + 1'b1;  // wraps 7 -> 0 on the last bit
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (timer == '0) begin
                    state_next = STOP;
                    timer_next = TLOAD;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
`endif
            STOP: begin
                if (timer == '0) begin
                    state_next = IDLE;
                    timer_next = TLOAD;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = TLOAD;
                idx_next   = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state != IDLE);
        done = (state == STOP) && (timer == '0);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[idx_next];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = ^shreg_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    assign bus.tx_o   = tx_q;
    assign bus.busy_o = busy;
    assign bus.done_o = done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed self-checking bench for uart_tx at CLKS_PER_BIT=4.
module tb_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic resetn;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0] sb[$];

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"},   8'(bus.tx_o),   8'h01);
        check({tag, "_busy"}, 8'(bus.busy_o), 8'h00);
        check({tag, "_done"}, 8'(bus.done_o), 8'h00);
    endtask

    // Called at a negedge with the DUT idle. mode 0: single pulse,
    // 1: start_i left high, 2: d_i toggled and start_i pulsed mid-frame.
    task automatic frame(input logic [7:0] d, input int unsigned mode);
        logic [7:0] got;
        logic [7:0] exp_d;
        logic       exp_tx;
        int unsigned b;
        got = '0;
        bus.d_i = d;
        bus.start_i = 1'b1;
        sb.push_back(d);
        @(negedge clk);  // first cycle after acceptance
        exp_d = sb[0];
        if (mode != 1) bus.start_i = 1'b0;
        for (int unsigned k = 1; k <= FRAME; k++) begin
            b = (k - 1) / CPB;
            if (b == 0)                 exp_tx = 1'b0;
            else if (b <= 8)            exp_tx = exp_d[b-1];
            else if (NBITS == 11 && b == 9) exp_tx = ^exp_d;
            else                        exp_tx = 1'b1;
            check("frame_tx",   8'(bus.tx_o),   8'(exp_tx));
            check("frame_busy", 8'(bus.busy_o), 8'h01);
            check("frame_done", 8'(bus.done_o), 8'(k == FRAME));
            if ((k - 1) % CPB == CPB / 2 && b >= 1 && b <= 8) got[b-1] = bus.tx_o;
            if (mode == 2) begin
                bus.d_i = ~bus.d_i;
                bus.start_i = (k % 7 == 0) && (k < FRAME);
            end
            @(negedge clk);
        end
        // idle cycle after the stop bit
        check("after_tx",   8'(bus.tx_o),   8'h01);
        check("after_busy", 8'(bus.busy_o), 8'h00);
        check("after_done", 8'(bus.done_o), 8'h00);
        if (sb.size() > 0) check("sb_byte", got, sb.pop_front());
        else check("sb_underflow", 8'(sb.size()), 8'h01);
    endtask

    initial begin
        // Reset with start_i high: must not be accepted
        resetn = 1'b0;
        bus.d_i = 8'h55;
        bus.start_i = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        bus.start_i = 1'b0;
        resetn = 1'b1;

        // Idle 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle("idle");
        end

        // Basic frame
        frame(8'hA5, 0);
        repeat (3) @(negedge clk);
        check_idle("gap1");

        // Back-to-back frames with start_i held
        frame(8'h00, 1);
        frame(8'hFF, 0);
        repeat (2) @(negedge clk);
        check_idle("gap2");

        // Mid-frame d_i noise and start_i pulses are ignored
        frame(8'h3C, 2);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            check_idle("no_extra");
        end

`ifdef UART_TX_PARITY_EN
        frame(8'h07, 0);
        @(negedge clk);
        frame(8'hA5, 0);
        @(negedge clk);
`endif

        // Reset for one cycle at cycle 15 of a frame
        bus.d_i = 8'h96;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("abort_started", 8'(bus.tx_o), 8'h00);
        repeat (14) @(negedge clk);
        check("abort_busy_pre", 8'(bus.busy_o), 8'h01);
        resetn = 1'b0;
        @(negedge clk);
        check_idle("abort");
        resetn = 1'b1;
        for (int i = 0; i < FRAME + 10; i++) begin
            @(negedge clk);
            check_idle("abort_after");
        end

        // First acceptance right after reset release
        resetn = 1'b0;
        bus.start_i = 1'b1;
        @(negedge clk);
        check_idle("rst2");
        resetn = 1'b1;
        frame(8'h81, 0);

        check("sb_empty", 8'(sb.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
